fft_frame_feeder: RTL and testbench



---
 rtl/fft_feeder_pkg.sv | 17 +
 rtl/sync_fifo_fwft.sv | 50 +++++
 rtl/fft_frame_feeder.sv | 112 +++++++++++
 tb/tb_fft_frame_feeder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_feeder_pkg.sv
// Shared constants, FSM encoding and sample packing for the FFT transmit feeder.
package fft_feeder_pkg;

  localparam int unsigned FFT_LEN  = 256;
  localparam int unsigned DATA_W   = 12;
  localparam int unsigned FFT_IN_W = 32;
  localparam int unsigned CFG_W    = 8;
  localparam logic [CFG_W-1:0] CFG_FWD = 8'h01;

  typedef enum logic [1:0] {IDLE, CFG, RUN, DONE} feeder_state_e;

  // Real part in [15:0], imaginary part (always zero) in [31:16].
  function automatic logic [FFT_IN_W-1:0] pack_sample(input logic signed [15:0] re);
    return {16'h0000, re};
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; head word is always visible on dout.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push, pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  // A push into a full FIFO is only taken when the head is leaving the same cycle.
  assign push  = wr_en && (!full || rd_en);
  assign pop   = rd_en && !empty;
  assign dout  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fft_frame_feeder.sv
// Captures one frame of ADC samples, configures the FFT core, and streams the frame over AXI-Stream.
module fft_frame_feeder
  import fft_feeder_pkg::*;
#(
  parameter int unsigned FFT_LEN    = fft_feeder_pkg::FFT_LEN,
  parameter int unsigned DATA_W     = fft_feeder_pkg::DATA_W,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  CFG_FWD    = fft_feeder_pkg::CFG_FWD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              frame_start,
  output logic [7:0]        fft_s_config_tdata,
  output logic              fft_s_config_tvalid,
  input  logic              fft_s_config_tready,
  output logic [31:0]       fft_s_data_tdata,
  output logic              fft_s_data_tvalid,
  input  logic              fft_s_data_tready,
  output logic              fft_s_data_tlast,
  output logic              frame_busy,
  output logic              frame_done,
  output logic              sample_overflow
);

  localparam int unsigned CNT_W = $clog2(FFT_LEN) + 1;

  feeder_state_e     state_q, state_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic              ovf_q, ovf_d;

  logic              fifo_wr, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              data_hs, last_beat;

  assign fifo_wr   = (state_q == RUN) && adc_valid && !fifo_full &&
                     (wr_cnt_q < CNT_W'(FFT_LEN));
  assign data_hs   = !fifo_empty && fft_s_data_tready;
  assign last_beat = !fifo_empty && (rd_cnt_q == CNT_W'(FFT_LEN - 1));

  sync_fifo_fwft #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (fifo_wr),
    .din   (adc_data),
    .full  (fifo_full),
    .rd_en (data_hs),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d  = CFG;
          wr_cnt_d = '0;
          rd_cnt_d = '0;
          ovf_d    = 1'b0;
        end
      end
      CFG: begin
        if (fft_s_config_tready) state_d = RUN;
      end
      RUN: begin
        if (fifo_wr) wr_cnt_d = wr_cnt_q + 1'b1;
        if (adc_valid && fifo_full) ovf_d = 1'b1;
        if (data_hs) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fft_s_config_tdata  = CFG_FWD;
    fft_s_config_tvalid = (state_q == CFG);
    fft_s_data_tvalid   = !fifo_empty;
    // Gate the head word so tdata reads zero whenever nothing is being offered.
    fft_s_data_tdata    = fifo_empty ? '0 : pack_sample(16'(signed'(fifo_dout)));
    fft_s_data_tlast    = last_beat;
    frame_busy          = (state_q == CFG) || (state_q == RUN);
    frame_done          = (state_q == DONE);
    sample_overflow     = ovf_q;
  end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Self-checking bench for fft_frame_feeder: scoreboard of accepted samples plus a reference FSM/occupancy model.
module tb_fft_frame_feeder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned NFR   = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] adc_data;
  logic        adc_valid, frame_start;
  logic [7:0]  cfg_tdata;
  logic        cfg_tvalid, cfg_tready;
  logic [31:0] d_tdata;
  logic        d_tvalid, d_tready, d_tlast;
  logic        frame_busy, frame_done, sample_overflow;

  fft_frame_feeder #(
    .FFT_LEN    (256),
    .DATA_W     (12),
    .FIFO_DEPTH (DEPTH),
    .CFG_FWD    (8'h01)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .adc_data            (adc_data),
    .adc_valid           (adc_valid),
    .frame_start         (frame_start),
    .fft_s_config_tdata  (cfg_tdata),
    .fft_s_config_tvalid (cfg_tvalid),
    .fft_s_config_tready (cfg_tready),
    .fft_s_data_tdata    (d_tdata),
    .fft_s_data_tvalid   (d_tvalid),
    .fft_s_data_tready   (d_tready),
    .fft_s_data_tlast    (d_tlast),
    .frame_busy          (frame_busy),
    .frame_done          (frame_done),
    .sample_overflow     (sample_overflow)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    total_cnt++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  function automatic logic [31:0] sext(input logic [11:0] d);
    return {16'h0000, {4{d[11]}}, d};
  endfunction

  typedef struct {
    logic [11:0] din;
    logic [31:0] exp;
  } vec_t;
  localparam int NV = 7;
  vec_t tbl[NV];

  // Reference model: updated at each negedge to describe the next clock cycle.
  typedef enum {M_IDLE, M_CFG, M_RUN, M_DONE} mstate_e;
  mstate_e     m_st = M_IDLE;
  int          m_occ = 0, m_wr = 0, m_rd = 0, m_beats = 0, m_done = 0;
  logic        m_ovf = 1'b0;
  logic [31:0] sb[$];
  logic [31:0] cur_exp = '0;
  logic        stall_q = 1'b0;
  logic [32:0] stall_word = '0;

  always @(negedge clk) begin
    logic push, pop;
    logic [31:0] e;
    if (!rst_n) begin
      m_st = M_IDLE; m_occ = 0; m_wr = 0; m_rd = 0; m_ovf = 1'b0;
      sb.delete(); stall_q = 1'b0;
    end else begin
      chk("busy", frame_busy, (m_st == M_CFG) || (m_st == M_RUN));
      chk("done", frame_done, m_st == M_DONE);
      chk("cfg_valid", cfg_tvalid, m_st == M_CFG);
      if (m_st == M_CFG) chk("cfg_data", cfg_tdata, 8'h01);
      chk("data_valid", d_tvalid, m_occ != 0);
      chk("overflow", sample_overflow, m_ovf);
      if (m_st == M_DONE) m_done++;
      if (stall_q) begin
        chk("hold_valid", d_tvalid, 1'b1);
        chk("hold_word", {d_tlast, d_tdata}, stall_word);
      end
      stall_q    = d_tvalid && !d_tready;
      stall_word = {d_tlast, d_tdata};
      if (d_tvalid && d_tready) begin
        if (sb.size() == 0) fail_now("sb_underflow");
        else begin
          e = sb.pop_front();
          chk("tdata", d_tdata, e);
        end
        chk("tlast", d_tlast, m_rd == NFR - 1);
        m_beats++;
      end
      pop  = (m_occ != 0) && d_tready;
      push = 1'b0;
      case (m_st)
        M_IDLE: if (frame_start) begin
          m_st = M_CFG; m_ovf = 1'b0; m_wr = 0; m_rd = 0; m_beats = 0; m_done = 0;
        end
        M_CFG: if (cfg_tready) m_st = M_RUN;
        M_RUN: begin
          push = adc_valid && (m_occ < DEPTH) && (m_wr < NFR);
          if (adc_valid && m_occ == DEPTH) m_ovf = 1'b1;
          if (push) begin sb.push_back(cur_exp); m_wr++; end
          if (pop) begin m_rd++; if (m_rd == NFR) m_st = M_DONE; end
          m_occ = m_occ + int'(push) - int'(pop);
        end
        default: m_st = M_IDLE;
      endcase
    end
  end

  logic bp = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    if (bp) d_tready = ~d_tready;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cfg_valid"}, cfg_tvalid, 1'b0);
    chk({tag, "_cfg_data"}, cfg_tdata, 8'h01);
    chk({tag, "_d_valid"}, d_tvalid, 1'b0);
    chk({tag, "_d_last"}, d_tlast, 1'b0);
    chk({tag, "_d_data"}, d_tdata, 32'h0);
    chk({tag, "_busy"}, frame_busy, 1'b0);
    chk({tag, "_done"}, frame_done, 1'b0);
    chk({tag, "_ovf"}, sample_overflow, 1'b0);
  endtask

  // mode 0 ramp, 1 table vectors, 2 config stall, 3 backpressure, 4 ignored start, 5 reset at beat 100
  task automatic run_frame(input int mode);
    int k;
    bit ok;
    d_tready   = 1'b1;
    cfg_tready = (mode == 2) ? 1'b0 : 1'b1;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    if (mode == 2) begin
      adc_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
        adc_data = 12'(i + 100);
        cur_exp  = sext(adc_data);
        step();
      end
      adc_valid  = 1'b0;
      cfg_tready = 1'b1;
    end
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (m_st == M_RUN) ok = 1'b1;
      else step();
    end
    if (!ok) begin fail_now("wait_run"); return; end
    bp = (mode == 3);
    if (mode == 3) begin
      k = 0;
      while (m_wr < NFR && k < 3000) begin
        adc_valid = 1'b1;
        adc_data  = 12'(k);
        cur_exp   = sext(adc_data);
        step();
        k++;
      end
      if (m_wr < NFR) fail_now("bp_fill");
    end else begin
      for (int i = 0; i < NFR; i++) begin
        if (mode == 1 && i < NV) begin
          adc_data = tbl[i].din;
          cur_exp  = tbl[i].exp;
        end else begin
          adc_data = 12'(i);
          cur_exp  = sext(adc_data);
        end
        adc_valid   = 1'b1;
        frame_start = (mode == 4) && (i == 50);
        step();
        if (mode == 5 && m_beats >= 100) begin
          rst_n = 1'b0; adc_valid = 1'b0; frame_start = 1'b0;
          #1;
          check_reset_outputs("midrst");
          step(); step();
          rst_n = 1'b1;
          step();
          return;
        end
      end
    end
    adc_valid   = 1'b0;
    frame_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      if (m_st == M_IDLE) ok = 1'b1;
      else step();
    end
    bp = 1'b0;
    d_tready = 1'b1;
    if (!ok) fail_now("wait_idle");
    chk("beats", m_beats, NFR);
    chk("done_pulses", m_done, 1);
    chk("ovf_end", sample_overflow, (mode == 3) ? 1'b1 : 1'b0);
    step();
  endtask

  initial begin
    tbl[0] = '{12'h800, 32'h0000_F800};
    tbl[1] = '{12'h7FF, 32'h0000_07FF};
    tbl[2] = '{12'hFFF, 32'h0000_FFFF};
    tbl[3] = '{12'h001, 32'h0000_0001};
    tbl[4] = '{12'h000, 32'h0000_0000};
    tbl[5] = '{12'hA5A, 32'h0000_FA5A};
    tbl[6] = '{12'h5A5, 32'h0000_05A5};

    rst_n = 1'b0; adc_data = '0; adc_valid = 1'b0; frame_start = 1'b0;
    cfg_tready = 1'b1; d_tready = 1'b1;
    repeat (3) step();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    step();

    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);
    run_frame(5);
    run_frame(0);
    run_frame(4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
